reservation_alu2_issue_ctrl: RTL and testbench

- Allocation, age-ordering and issue controller for the ALU2 reservation station: a bank of ENTRY_N single-instruction entries, each capturing operands from the three CDB channels.
- Steers each dispatched instruction into a free entry and tracks dispatch order.
- Each cycle, selects the oldest entry whose operands are both valid and issues it to the ALU2 execution unit.
- On flush, clears all entries.

---
 rtl/reservation_alu2_issue_ctrl_if.sv | 30 +++
 rtl/reservation_alu2_issue_ctrl.sv | 106 ++++++++++
 tb/tb_reservation_alu2_issue_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/reservation_alu2_issue_ctrl_if.sv
// Dispatch/issue handshake bundle between the ALU2 reservation station
// entries, the dispatch stage and the ALU2 execution unit.
interface reservation_alu2_issue_ctrl_if #(
   parameter int unsigned ENTRY_N = 4,
   parameter int unsigned ENTRY_W = 2
);
   logic               iFLUSH;
   logic               iDISPATCH_VALID;
   logic               oDISPATCH_LOCK;
   logic [ENTRY_N-1:0] oREGIST_VALID;
   logic [ENTRY_N-1:0] iENTRY_MATCHING;
   logic               iEX_LOCK;
   logic               oISSUE_VALID;
   logic [ENTRY_W-1:0] oISSUE_SEL;
   logic [ENTRY_N-1:0] oEXOUT_VALID;
   logic [ENTRY_N-1:0] oREMOVE_VALID;
   logic [ENTRY_W:0]   oCOUNT;

   modport master (
      output iFLUSH, iDISPATCH_VALID, iENTRY_MATCHING, iEX_LOCK,
      input  oDISPATCH_LOCK, oREGIST_VALID, oISSUE_VALID, oISSUE_SEL,
             oEXOUT_VALID, oREMOVE_VALID, oCOUNT
   );

   modport slave (
      input  iFLUSH, iDISPATCH_VALID, iENTRY_MATCHING, iEX_LOCK,
      output oDISPATCH_LOCK, oREGIST_VALID, oISSUE_VALID, oISSUE_SEL,
             oEXOUT_VALID, oREMOVE_VALID, oCOUNT
   );
endinterface

// File: rtl/reservation_alu2_issue_ctrl.sv
// ALU2 reservation station controller: allocates free entries, keeps dispatch
// age order and issues the oldest entry whose operands are both ready.
module reservation_alu2_issue_ctrl #(
   parameter int unsigned ENTRY_N = 4,
   parameter int unsigned ENTRY_W = 2
) (
   input  logic                          iCLOCK,
   input  logic                          iRESET_SYNC,
   reservation_alu2_issue_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = ENTRY_W + 1;
   localparam logic [ENTRY_N-1:0] ONE_HOT0 = ENTRY_N'(1);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t             st;
   logic [ENTRY_N-1:0] occ;
   logic [ENTRY_W-1:0] age [ENTRY_N];
   logic [CNT_W-1:0]   cnt;

   logic [ENTRY_N-1:0] occ_nxt;
   logic [ENTRY_W-1:0] age_nxt [ENTRY_N];
   logic [ENTRY_W-1:0] age_ext [ENTRY_N+1];
   logic [CNT_W-1:0]   cnt_nxt;

   logic               cand_found;
   logic [ENTRY_W-1:0] cand;
   logic               free_found;
   logic [ENTRY_W-1:0] target;
   logic               lock_c;
   logic               issue_c;
   logic               accept_c;
   logic [ENTRY_W-1:0] sel_c;
   logic [ENTRY_W-1:0] wslot;

   // Oldest ready slot and lowest free entry
   always_comb begin
      cand_found = 1'b0;
      cand       = '0;
      free_found = 1'b0;
      target     = '0;
      for (int k = 0; k < ENTRY_N; k++) begin
         if (!cand_found && (CNT_W'(k) < cnt) && bus.iENTRY_MATCHING[age[k]]) begin
            cand_found = 1'b1;
            cand       = ENTRY_W'(k);
         end
         if (!free_found && !occ[k]) begin
            free_found = 1'b1;
            target     = ENTRY_W'(k);
         end
      end
   end

   always_comb begin
      lock_c   = (st == ST_FLUSH) || (cnt == CNT_W'(ENTRY_N));
      issue_c  = cand_found && !bus.iEX_LOCK && !bus.iFLUSH && (st == ST_RUN);
      accept_c = bus.iDISPATCH_VALID && !lock_c && !bus.iFLUSH;
      sel_c    = issue_c ? age[cand] : '0;
   end

   assign bus.oDISPATCH_LOCK = lock_c;
   assign bus.oREGIST_VALID  = accept_c ? (ONE_HOT0 << target) : '0;
   assign bus.oISSUE_VALID   = issue_c;
   assign bus.oISSUE_SEL     = sel_c;
   assign bus.oEXOUT_VALID   = issue_c ? (ONE_HOT0 << sel_c) : '0;
   assign bus.oREMOVE_VALID  = bus.iFLUSH ? '1 : '0;
   assign bus.oCOUNT         = cnt;

   // Queue compaction on issue, append on dispatch; a same-cycle issue frees one slot first
   always_comb begin
      for (int k = 0; k < ENTRY_N; k++) age_ext[k] = age[k];
      age_ext[ENTRY_N] = '0;
      for (int k = 0; k < ENTRY_N; k++) begin
         age_nxt[k] = (issue_c && (ENTRY_W'(k) >= cand)) ? age_ext[k+1] : age[k];
      end
      wslot   = ENTRY_W'(cnt) - ENTRY_W'(issue_c);
      occ_nxt = occ;
      if (issue_c) occ_nxt[sel_c] = 1'b0;
      if (accept_c) begin
         age_nxt[wslot]  = target;
         occ_nxt[target] = 1'b1;
      end
      cnt_nxt = cnt + CNT_W'(accept_c) - CNT_W'(issue_c);
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         st  <= ST_RUN;
         occ <= '0;
         cnt <= '0;
         for (int k = 0; k < ENTRY_N; k++) age[k] <= '0;
      end else if (bus.iFLUSH) begin
         st  <= ST_FLUSH;
         occ <= '0;
         cnt <= '0;
         for (int k = 0; k < ENTRY_N; k++) age[k] <= '0;
      end else begin
         st  <= ST_RUN;
         occ <= occ_nxt;
         cnt <= cnt_nxt;
         for (int k = 0; k < ENTRY_N; k++) age[k] <= age_nxt[k];
      end
   end

endmodule

// File: tb/tb_reservation_alu2_issue_ctrl.sv
// Directed vector bench for the ALU2 reservation station issue controller.
module tb_reservation_alu2_issue_ctrl;

   logic iCLOCK = 1'b0;
   logic iRESET_SYNC;

   always #5 iCLOCK = ~iCLOCK;

   reservation_alu2_issue_ctrl_if #(.ENTRY_N(4), .ENTRY_W(2)) bus ();

   reservation_alu2_issue_ctrl #(.ENTRY_N(4), .ENTRY_W(2)) dut (
      .iCLOCK      (iCLOCK),
      .iRESET_SYNC (iRESET_SYNC),
      .bus         (bus)
   );

   typedef struct packed {
      logic       rst;
      logic       fl;
      logic       dv;
      logic [3:0] m;
      logic       exl;
      logic       e_lock;
      logic [3:0] e_reg;
      logic       e_iv;
      logic [1:0] e_sel;
      logic [3:0] e_exo;
      logic [3:0] e_rem;
      logic [2:0] e_cnt;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and check the outputs mid-cycle
   task automatic step(input vec_t v, input int idx);
      @(negedge iCLOCK);
      iRESET_SYNC         = v.rst;
      bus.iFLUSH          = v.fl;
      bus.iDISPATCH_VALID = v.dv;
      bus.iENTRY_MATCHING = v.m;
      bus.iEX_LOCK        = v.exl;
      #1;
      chk("lock",   idx, 8'(bus.oDISPATCH_LOCK), 8'(v.e_lock));
      chk("regist", idx, 8'(bus.oREGIST_VALID),  8'(v.e_reg));
      chk("issue",  idx, 8'(bus.oISSUE_VALID),   8'(v.e_iv));
      chk("sel",    idx, 8'(bus.oISSUE_SEL),     8'(v.e_sel));
      chk("exout",  idx, 8'(bus.oEXOUT_VALID),   8'(v.e_exo));
      chk("remove", idx, 8'(bus.oREMOVE_VALID),  8'(v.e_rem));
      chk("count",  idx, 8'(bus.oCOUNT),         8'(v.e_cnt));
   endtask

   initial begin
      //               rst   fl    dv    m        exl   lock  reg      iv    sel    exo      rem      cnt
      // fill four entries, fifth dispatch ignored
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0001,1'b0,2'd0,4'b0000,4'b0000,3'd0});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0010,1'b0,2'd0,4'b0000,4'b0000,3'd1});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0100,1'b0,2'd0,4'b0000,4'b0000,3'd2});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b1000,1'b0,2'd0,4'b0000,4'b0000,3'd3});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b1,4'b0000,1'b0,2'd0,4'b0000,4'b0000,3'd4});
      // out-of-order issue, then oldest-matching first
      vecs.push_back('{1'b0,1'b0,1'b0,4'b0100,1'b0, 1'b1,4'b0000,1'b1,2'd2,4'b0100,4'b0000,3'd4});
      vecs.push_back('{1'b0,1'b0,1'b0,4'b0110,1'b0, 1'b0,4'b0000,1'b1,2'd1,4'b0010,4'b0000,3'd3});
      vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,1'b0, 1'b0,4'b0000,1'b0,2'd0,4'b0000,4'b0000,3'd2});
      // reset wins over a presented dispatch
      vecs.push_back('{1'b1,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0010,1'b0,2'd0,4'b0000,4'b0000,3'd2});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0001,1'b0,2'd0,4'b0000,4'b0000,3'd0});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0010,1'b0,2'd0,4'b0000,4'b0000,3'd1});
      // execution lock holds issue
      vecs.push_back('{1'b0,1'b0,1'b0,4'b0011,1'b1, 1'b0,4'b0000,1'b0,2'd0,4'b0000,4'b0000,3'd2});
      vecs.push_back('{1'b0,1'b0,1'b0,4'b0011,1'b1, 1'b0,4'b0000,1'b0,2'd0,4'b0000,4'b0000,3'd2});
      vecs.push_back('{1'b0,1'b0,1'b0,4'b0011,1'b1, 1'b0,4'b0000,1'b0,2'd0,4'b0000,4'b0000,3'd2});
      vecs.push_back('{1'b0,1'b0,1'b0,4'b0011,1'b0, 1'b0,4'b0000,1'b1,2'd0,4'b0001,4'b0000,3'd2});
      vecs.push_back('{1'b0,1'b0,1'b0,4'b0011,1'b0, 1'b0,4'b0000,1'b1,2'd1,4'b0010,4'b0000,3'd1});
      // simultaneous dispatch and issue, then verify age order 0,2,3
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0001,1'b0,2'd0,4'b0000,4'b0000,3'd0});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0010,1'b0,2'd0,4'b0000,4'b0000,3'd1});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0100,1'b0,2'd0,4'b0000,4'b0000,3'd2});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0010,1'b0, 1'b0,4'b1000,1'b1,2'd1,4'b0010,4'b0000,3'd3});
      vecs.push_back('{1'b0,1'b0,1'b0,4'b1100,1'b0, 1'b0,4'b0000,1'b1,2'd2,4'b0100,4'b0000,3'd3});
      vecs.push_back('{1'b0,1'b0,1'b0,4'b1001,1'b0, 1'b0,4'b0000,1'b1,2'd0,4'b0001,4'b0000,3'd2});
      vecs.push_back('{1'b0,1'b0,1'b0,4'b1000,1'b0, 1'b0,4'b0000,1'b1,2'd3,4'b1000,4'b0000,3'd1});
      // full station flushed, one-cycle FLUSH lock, then entry 0 again
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0001,1'b0,2'd0,4'b0000,4'b0000,3'd0});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0010,1'b0,2'd0,4'b0000,4'b0000,3'd1});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0100,1'b0,2'd0,4'b0000,4'b0000,3'd2});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b1000,1'b0,2'd0,4'b0000,4'b0000,3'd3});
      vecs.push_back('{1'b0,1'b1,1'b1,4'b1111,1'b0, 1'b1,4'b0000,1'b0,2'd0,4'b0000,4'b1111,3'd4});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b1,4'b0000,1'b0,2'd0,4'b0000,4'b0000,3'd0});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0001,1'b0,2'd0,4'b0000,4'b0000,3'd0});
      // held flush keeps FLUSH state
      vecs.push_back('{1'b0,1'b1,1'b0,4'b0000,1'b0, 1'b0,4'b0000,1'b0,2'd0,4'b0000,4'b1111,3'd1});
      vecs.push_back('{1'b0,1'b1,1'b0,4'b0000,1'b0, 1'b1,4'b0000,1'b0,2'd0,4'b0000,4'b1111,3'd0});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b1,4'b0000,1'b0,2'd0,4'b0000,4'b0000,3'd0});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0001,1'b0,2'd0,4'b0000,4'b0000,3'd0});
      // mid-operation reset with three entries occupied
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0010,1'b0,2'd0,4'b0000,4'b0000,3'd1});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0100,1'b0,2'd0,4'b0000,4'b0000,3'd2});
      vecs.push_back('{1'b1,1'b0,1'b0,4'b0000,1'b0, 1'b0,4'b0000,1'b0,2'd0,4'b0000,4'b0000,3'd3});
      vecs.push_back('{1'b0,1'b0,1'b0,4'b1111,1'b0, 1'b0,4'b0000,1'b0,2'd0,4'b0000,4'b0000,3'd0});
      vecs.push_back('{1'b0,1'b0,1'b1,4'b0000,1'b0, 1'b0,4'b0001,1'b0,2'd0,4'b0000,4'b0000,3'd0});

      iRESET_SYNC         = 1'b1;
      bus.iFLUSH          = 1'b0;
      bus.iDISPATCH_VALID = 1'b0;
      bus.iENTRY_MATCHING = '0;
      bus.iEX_LOCK        = 1'b0;
      repeat (2) @(posedge iCLOCK);
      @(negedge iCLOCK);
      iRESET_SYNC = 1'b0;
      #1;
      chk("rst_lock",   -1, 8'(bus.oDISPATCH_LOCK), 8'h00);
      chk("rst_count",  -1, 8'(bus.oCOUNT),         8'h00);
      chk("rst_issue",  -1, 8'(bus.oISSUE_VALID),   8'h00);
      chk("rst_regist", -1, 8'(bus.oREGIST_VALID),  8'h00);

      foreach (vecs[i]) step(vecs[i], i);

      // Entry 1 registered while entry 0 issues into the freed slot 0
      step('{1'b0,1'b0,1'b1,4'b0011,1'b0, 1'b0,4'b0010,1'b1,2'd0,4'b0001,4'b0000,3'd1}, 100);
      step('{1'b0,1'b0,1'b0,4'b0010,1'b0, 1'b0,4'b0000,1'b1,2'd1,4'b0010,4'b0000,3'd1}, 101);
      step('{1'b0,1'b0,1'b0,4'b0000,1'b0, 1'b0,4'b0000,1'b0,2'd0,4'b0000,4'b0000,3'd0}, 102);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
